// File: rtl/up_down_sweep_ctrl_if.sv
// Signal bundle between up_down_sweep_ctrl, its host (start/done handshake)
// and the attached up/down counter. master = controller side.
interface up_down_sweep_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int PASS_W = 8
);
  logic              start;
  logic [WIDTH-1:0]  limit;
  logic [PASS_W-1:0] passes;
  logic              pause;
  logic              abort;
  logic [WIDTH-1:0]  count;
  logic              cnt_enable;
  logic              cnt_reverse;
  logic              cnt_clear;
  logic              busy;
  logic              done;
  logic              peak;
  logic [PASS_W-1:0] pass_left;

  modport master (
    input  start, limit, passes, pause, abort, count,
    output cnt_enable, cnt_reverse, cnt_clear, busy, done, peak, pass_left
  );

  modport slave (
    output start, limit, passes, pause, abort, count,
    input  cnt_enable, cnt_reverse, cnt_clear, busy, done, peak, pass_left
  );
endinterface

// File: rtl/up_down_sweep_ctrl.sv
// Triangular-sweep sequencer for an up/down counter: CLEAR, then per pass UP to
// the latched limit, TOP, DOWN to zero. Optional abort logic: SWEEP_ABORT_EN.
module up_down_sweep_ctrl #(
  parameter int WIDTH  = 16,
  parameter int PASS_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  up_down_sweep_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_UP    = 3'd2,
    S_TOP   = 3'd3,
    S_DOWN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_lim;
  logic [PASS_W-1:0] r_pass_left;
  logic [PASS_W-1:0] w_pass_next;
  logic [PASS_W-1:0] w_pass_dec;
  logic              r_busy;
  logic              r_done;
  logic              r_clear;
  logic              w_en;
  logic              w_rev;
  logic              w_peak;
  logic              w_at_lim;
  logic              w_at_zero;
  logic              w_sweeping;
  logic              w_hold;
  logic              w_abort;
  logic              w_accept;

  assign w_at_lim   = (bus.count == r_lim);
  assign w_at_zero  = (bus.count == {WIDTH{1'b0}});
  assign w_sweeping = (r_state == S_UP) || (r_state == S_TOP) || (r_state == S_DOWN);
  assign w_hold     = bus.pause && w_sweeping;
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_pass_dec = r_pass_left - {{(PASS_W-1){1'b0}}, 1'b1};

`ifdef SWEEP_ABORT_EN
  assign w_abort = bus.abort && (w_sweeping || (r_state == S_CLEAR));
`else
  logic w_unused_abort;
  assign w_unused_abort = bus.abort;
  assign w_abort        = 1'b0;
`endif

  // Next-state decode plus the count-dependent counter controls.
  always_comb begin
    w_next      = r_state;
    w_pass_next = r_pass_left;
    w_en        = 1'b0;
    w_rev       = 1'b0;
    w_peak      = (r_state == S_TOP) && !bus.pause;
    if (w_abort) begin
      w_next = S_DONE;
    end else if (w_hold) begin
      w_next = r_state;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_next      = S_CLEAR;
            w_pass_next = bus.passes;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_CLEAR: begin
          if (r_pass_left == {PASS_W{1'b0}}) w_next = S_DONE;
          else                               w_next = S_UP;
        end
        S_UP: begin
          if (w_at_lim) w_next = S_TOP;
          else          w_en   = 1'b1;
        end
        S_TOP: begin
          w_next = S_DOWN;
        end
        S_DOWN: begin
          if (w_at_zero) begin
            w_pass_next = w_pass_dec;
            if (w_pass_dec == {PASS_W{1'b0}}) w_next = S_DONE;
            else                              w_next = S_UP;
          end else begin
            w_en  = 1'b1;
            w_rev = 1'b1;
          end
        end
        S_DONE: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // State, latched limit, pass counter and the state-derived strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lim       <= {WIDTH{1'b0}};
      r_pass_left <= {PASS_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pass_left <= w_pass_next;
      if (w_accept) r_lim <= bus.limit;
      else          r_lim <= r_lim;
      r_busy      <= (w_next == S_CLEAR) || (w_next == S_UP) ||
                     (w_next == S_TOP)   || (w_next == S_DOWN);
      r_done      <= (w_next == S_DONE);
      r_clear     <= (w_next == S_CLEAR);
    end
  end

  assign bus.cnt_enable  = w_en;
  assign bus.cnt_reverse = w_rev;
  assign bus.peak        = w_peak;
  assign bus.cnt_clear   = r_clear;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass_left   = r_pass_left;

endmodule

// File: tb/tb_up_down_sweep_ctrl.sv
// Bench for up_down_sweep_ctrl: a behavioural counter plus a per-cycle expected
// schedule built from the pass arithmetic (limit up, peak, limit down, zero).
module tb_up_down_sweep_ctrl;
  localparam int WIDTH  = 16;
  localparam int PASS_W = 8;
  localparam logic [2:0] P_IDLE = 3'd0, P_CLEAR = 3'd1, P_UP = 3'd2,
                         P_TOP = 3'd3, P_DOWN = 3'd4, P_DONE = 3'd5;

  typedef struct packed {
    logic [2:0]        ph;
    logic              clr;
    logic              en;
    logic              rev;
    logic              peak;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] cnt = 16'd0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [PASS_W-1:0] last_pl = 8'd0;

  up_down_sweep_ctrl_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus();
  up_down_sweep_ctrl #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Counter being sequenced: clear wins, else step up or down when enabled.
  always @(posedge clk) begin
    if (bus.cnt_clear)       cnt <= 16'd0;
    else if (bus.cnt_enable) cnt <= bus.cnt_reverse ? cnt - 16'd1 : cnt + 16'd1;
  end
  assign bus.count = cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] ph, input logic [5:0] f, input logic [PASS_W-1:0] pl);
    exp_t e;
    e.ph = ph;
    {e.clr, e.en, e.rev, e.peak, e.busy, e.done} = f;
    e.pl = pl;
    return e;
  endfunction

  function automatic logic [31:0] ev(input exp_t e);
    return 32'({e.clr, e.en, e.en & e.rev, e.peak, e.busy, e.done, e.pl});
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({bus.cnt_clear, bus.cnt_enable, bus.cnt_enable & bus.cnt_reverse,
                bus.peak, bus.busy, bus.done, bus.pass_left});
  endfunction

  task automatic build(input int lim, input int np);
    q.delete();
    q.push_back(mk(P_CLEAR, 6'b100010, PASS_W'(np)));
    for (int p = np; p > 0; p--) begin
      for (int i = 0; i < lim; i++) q.push_back(mk(P_UP, 6'b010010, PASS_W'(p)));
      q.push_back(mk(P_UP,  6'b000010, PASS_W'(p)));
      q.push_back(mk(P_TOP, 6'b000110, PASS_W'(p)));
      for (int i = 0; i < lim; i++) q.push_back(mk(P_DOWN, 6'b011010, PASS_W'(p)));
      q.push_back(mk(P_DOWN, 6'b000010, PASS_W'(p)));
    end
    q.push_back(mk(P_DONE, 6'b000001, 8'd0));
  endtask

  // pmode: 0 none, 1 random pause, 2 four-cycle pause in DOWN at count 6
  task automatic run(input string tag, input int lim, input int np, input int pmode,
                     input bit junk, input bit do_abort, input bit do_reset);
    int ncyc = 0, done_cyc = -1, npause = 0, prem = 0, npeak = 0, nbusy = 0;
    bit pused = 1'b0, aborted = 1'b0, was_reset = 1'b0, ab;
    exp_t h, e;
    @(negedge clk);
    bus.start = 1'b1; bus.limit = WIDTH'(lim); bus.passes = PASS_W'(np);
    bus.pause = 1'($urandom_range(0, 1)); bus.abort = 1'($urandom_range(0, 1));
    #1 chk({tag, "/start_idle"}, obs_vec(), ev(mk(P_IDLE, 6'b000000, last_pl)));
    build(lim, np);
    while (q.size() > 0 && ncyc < 4000) begin
      @(negedge clk);
      ncyc++;
      h = q[0];
      bus.start  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.limit  = WIDTH'($urandom);
      bus.passes = PASS_W'($urandom);
      bus.abort  = 1'b0;
      bus.pause  = 1'b0;
      if (pmode == 1) bus.pause = ($urandom_range(0, 3) == 0);
      if (pmode == 2 && !pused && h.ph == P_DOWN && cnt == 16'd6) begin
        prem = 4; pused = 1'b1;
      end
      if (prem > 0) begin bus.pause = 1'b1; prem--; end
      if (do_abort && h.ph == P_UP && cnt == 16'd7) bus.abort = 1'b1;
      if (do_reset && h.ph == P_UP && cnt == 16'd5) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk({tag, "/after_reset"}, obs_vec(), 32'd0);
        last_pl = 8'd0; was_reset = 1'b1;
        q.delete();
        continue;
      end
      #1;
      ab = 1'b0;
`ifdef SWEEP_ABORT_EN
      ab = bus.abort && (h.ph inside {P_CLEAR, P_UP, P_TOP, P_DOWN});
`endif
      e = h;
      if (ab) begin
        e.en = 1'b0;
        if (bus.pause && h.ph == P_TOP) e.peak = 1'b0;
        aborted = 1'b1;
        q.delete();
        q.push_back(mk(P_DONE, 6'b000001, h.pl));
        q.push_front(e);
        void'(q.pop_front());
      end else if (bus.pause && (h.ph inside {P_UP, P_TOP, P_DOWN})) begin
        e.en = 1'b0; e.peak = 1'b0;
        npause++;
        if (pmode == 2) chk({tag, "/pause_hold"}, 32'(cnt), 32'd6);
      end else begin
        void'(q.pop_front());
      end
      chk({tag, "/cycle"}, obs_vec(), ev(e));
      if (bus.done && done_cyc < 0) done_cyc = ncyc;
      if (bus.peak) npeak++;
      if (bus.busy) nbusy++;
      last_pl = e.pl;
    end
    if (ncyc >= 4000) chk({tag, "/timeout"}, 32'(ncyc), 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    #1 chk({tag, "/end_idle"}, obs_vec(), ev(mk(P_IDLE, 6'b000000, last_pl)));
    if (!was_reset && !aborted) begin
      chk({tag, "/done_cycle"}, 32'(done_cyc), 32'(1 + np * (2 * lim + 3) + 1 + npause));
      chk({tag, "/busy_cycles"}, 32'(nbusy), 32'(1 + np * (2 * lim + 3) + npause));
      chk({tag, "/peaks"}, 32'(npeak), 32'(np));
    end
    if (aborted) chk({tag, "/abort_pass_left"}, 32'(bus.pass_left), 32'(np));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.limit = 16'd0; bus.passes = 8'd0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset_state", obs_vec(), 32'd0);
    reset = 1'b0;
    run("rst_mid",     8, 2, 0, 1'b0, 1'b0, 1'b1);
    run("single",      3, 1, 0, 1'b0, 1'b0, 1'b0);
    run("multi",       2, 3, 0, 1'b0, 1'b0, 1'b0);
    run("zero_passes", 5, 0, 0, 1'b0, 1'b0, 1'b0);
    run("zero_limit",  0, 2, 0, 1'b0, 1'b0, 1'b0);
    run("pause_junk",  9, 2, 2, 1'b1, 1'b0, 1'b0);
    run("abort",      10, 4, 0, 1'b0, 1'b1, 1'b0);
    run("after_abort", 1, 1, 0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run($sformatf("rand%0d", r), $urandom_range(0, 9), $urandom_range(0, 4), 1, 1'b1, 1'b0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
